imem_loader: RTL

- Write-side counterpart to the instruction fetch path: loads 16-bit instructions into instruction memory from a byte stream, e.g. from a UART or debug port.
- Holds the core in reset via core_hold until a load completes, then releases it so fetch starts from a valid program.
- Sits between the host byte-stream source and the write port of instruction memory.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the imem loader.
// The loader attaches to the master modport; the host/memory side attaches to slave.
interface imem_loader_if #(
  parameter int AW = 8
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads 16-bit instructions from a byte stream into instruction memory and holds the
// core in reset until a load completes. Optional checksum stage: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int            AW        = 8,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic          accept;
  logic          ready;
  logic [8:0]    remain;
  logic [7:0]    hi_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [15:0]   wdata_q;
  logic          hold_q;

  assign accept = bus.in_valid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_COUNT;
      end
      S_COUNT: begin
        ready = 1'b1;
        if (accept) state_nx = S_HI;
      end
      S_HI: begin
        ready = 1'b1;
        if (accept) state_nx = S_LO;
      end
      S_LO: begin
        ready = 1'b1;
        if (accept) begin
          if (remain == 9'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nx = S_CHK;
`else
            state_nx = S_DONE;
`endif
          end else begin
            state_nx = S_HI;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        ready = 1'b1;
        if (accept) state_nx = S_DONE;
      end
`endif
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The write is registered, so it lands in the first cycle of the following state;
  // the address advances at the end of that write cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain  <= '0;
      hi_q    <= '0;
      addr_q  <= BASE_ADDR;
      we_q    <= 1'b0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
    end else begin
      we_q <= 1'b0;
      if (we_q) addr_q <= addr_q + AW'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= BASE_ADDR;
            hold_q <= 1'b1;
          end
        end
        S_COUNT: begin
          if (accept) remain <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
        end
        S_HI: begin
          if (accept) hi_q <= bus.in_data;
        end
        S_LO: begin
          if (accept) begin
            wdata_q <= {hi_q, bus.in_data};
            we_q    <= 1'b1;
            remain  <= remain - 9'd1;
          end
        end
        S_DONE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          hold_q <= error;
`else
          hold_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            xor_q <= '0;
            err_q <= 1'b0;
          end
        end
        S_HI, S_LO: begin
          if (accept) xor_q <= xor_q ^ bus.in_data;
        end
        S_CHK: begin
          if (accept) err_q <= (bus.in_data != xor_q);
        end
        default: ;
      endcase
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign bus.in_ready  = ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_hold     = hold_q;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

endmodule
